patron_barras_rgb: RTL
======================

PATRON_BARRAS_RGB -- requirements
Module: patron_barras_rgb

Interface
REQ-001 SHALL have parameter H_OFFSET, default 216: first active column of the pattern.
REQ-002 SHALL have parameter V_OFFSET, default 27: first active row.
REQ-003 SHALL have parameter ANCHO_BARRA, default 100: bar width in pixels (vertical modes).
REQ-004 SHALL have parameter ALTO_BARRA, default 60: bar height in lines (horizontal mode).
REQ-005 SHALL have parameter NUM_BARRAS, default 8, legal range 1..8: number of bars.
REQ-006 SHALL have parameter VEL, default 4: scroll step in pixels per frame.
REQ-007 SHALL have parameter COLOR_W, default 8: bits per colour channel.
REQ-008 CLK  in  1  single system clock; all state on its rising edge.
REQ-009 RST_n  in  1  reset, asynchronous, active-low.
REQ-010 COLUMNA  in  11  current pixel column.
REQ-011 FILA  in  11  current pixel row.
REQ-012 FIN_TRAMA  in  1  one-cycle pulse marking end of frame.
REQ-013 MODO_SIG  in  1  one-cycle pulse requesting the next pattern mode.
REQ-014 R, G, B  out  COLOR_W each  registered pixel colour.
REQ-015 MODO  out  2  currently active mode.

Function
REQ-016 Palette index k SHALL map to: 0 white, 1 yellow, 2 cyan, 3 green, 4 magenta, 5 red, 6 blue, 7 black; "full" = all ones, "off" = all zeros.
REQ-017 Modes: 0 vertical bars, 1 horizontal bars, 2 scrolling vertical bars, 3 checkerboard.
REQ-018 Mode 0: x = COLUMNA-H_OFFSET; index = x/ANCHO_BARRA when 0<=x<NUM_BARRAS*ANCHO_BARRA, else black.
REQ-019 Mode 1: y = FILA-V_OFFSET; index = y/ALTO_BARRA when 0<=y<NUM_BARRAS*ALTO_BARRA, else black.
REQ-020 Mode 2: as mode 0 but position = (x + DESPL) mod (NUM_BARRAS*ANCHO_BARRA); columns outside active span black.
REQ-021 Mode 3: inside both active spans, white when (x/ANCHO_BARRA + y/ALTO_BARRA) is even, else black; outside, black.
REQ-022 COLUMNA<H_OFFSET (or FILA<V_OFFSET where used) SHALL produce black; no unsigned wrap to a bar colour.
REQ-023 Index computation SHALL use comparator chains or subtract-compare, no divider.
REQ-024 R/G/B SHALL be registered: latency exactly 1 CLK from COLUMNA/FILA/MODO to output.
REQ-025 MODO_SIG SHALL set a pending flag; mode advances (3 wraps to 0) only on the next FIN_TRAMA, then flag clears.
REQ-026 MODO_SIG and FIN_TRAMA in the same cycle SHALL advance the mode at that boundary.
REQ-027 Multiple MODO_SIG pulses within one frame SHALL advance the mode by one only.
REQ-028 DESPL SHALL be cleared to 0 whenever mode 2 is entered.
REQ-029 In mode 2 each FIN_TRAMA SHALL add VEL to DESPL modulo NUM_BARRAS*ANCHO_BARRA; DESPL held in other modes.

Reset
REQ-030 RST_n low SHALL immediately force R=G=B=0, MODO=0, DESPL=0, pending flag=0, regardless of CLK.
REQ-031 Reset mid-frame SHALL discard any pending mode request; first output after release follows mode 0.

Structure
REQ-032 Palette constants (8 entries), mode encodings and the FSM state type SHALL live in shared package barras_pkg.
REQ-033 Index-from-position logic SHALL be one sub-module, indice_barra (inputs position, width, count; output index, valid), instanced for columns and rows.
REQ-034 FSM (mode, pending, DESPL) and colour output register SHALL be in the top module.

Verification
REQ-035 Reset: RST_n=0 with random inputs -> R=G=B=0, MODO=0 asynchronously.
REQ-036 Mode 0 defaults: COLUMNA=216/316/816/916/100 -> next cycle white/yellow/blue/black/black.
REQ-037 MODO_SIG pulse mid-frame -> MODO stays 0 until FIN_TRAMA, becomes 1 the cycle after; 3 extra pulses same frame -> still 1.
REQ-038 Mode 2, VEL=4: after 1 FIN_TRAMA COLUMNA=312 -> yellow; after 200 frames DESPL=0, COLUMNA=216 -> white.
REQ-039 Mode 3: FILA=27, COLUMNA=216 -> white; COLUMNA=316 -> black; FILA=87, COLUMNA=316 -> white.
REQ-040 Simultaneous MODO_SIG+FIN_TRAMA in mode 3 -> MODO=0 next cycle; reset asserted mid-pending -> MODO=0, no later advance.

Source files
------------

// File: rtl/barras_pkg.sv
// Shared definitions for the RGB bar pattern generator: mode encodings,
// palette and position bus width.
package barras_pkg;

  // Width of the signed position bus (column/row minus offset, scroll sums).
  localparam int POS_W = 16;
  localparam int IDX_W = 3;

  // Pattern modes; the active mode is also the state of the control FSM.
  typedef enum logic [1:0] {
    MODO_VERT   = 2'd0,
    MODO_HORIZ  = 2'd1,
    MODO_SCROLL = 2'd2,
    MODO_DAMERO = 2'd3
  } modo_t;

  localparam logic [IDX_W-1:0] IDX_BLANCO = 3'd0;
  localparam logic [IDX_W-1:0] IDX_NEGRO  = 3'd7;

  // Palette entries as {R,G,B} on/off flags, indexed by bar number.
  localparam logic [2:0] PALETA [8] = '{
    3'b111,  // white
    3'b110,  // yellow
    3'b011,  // cyan
    3'b010,  // green
    3'b101,  // magenta
    3'b100,  // red
    3'b001,  // blue
    3'b000   // black
  };

  // Mode sequence 0 -> 1 -> 2 -> 3 -> 0.
  function automatic modo_t modo_siguiente(input modo_t m);
    case (m)
      MODO_VERT:   return MODO_HORIZ;
      MODO_HORIZ:  return MODO_SCROLL;
      MODO_SCROLL: return MODO_DAMERO;
      default:     return MODO_VERT;
    endcase
  endfunction

endpackage

// File: rtl/indice_barra.sv
// Bar index from a position: finds which of i_cuenta bars of width i_ancho
// the position falls in, using an add-and-compare chain instead of a divider.
// o_valido is low for negative positions or positions past the last bar.
module indice_barra
  import barras_pkg::*;
(
  input  logic [POS_W-1:0] i_pos,
  input  logic [POS_W-1:0] i_ancho,
  input  logic [3:0]       i_cuenta,
  output logic [IDX_W-1:0] o_indice,
  output logic             o_valido
);

  localparam int LIM_W = POS_W + 3;

  logic [LIM_W-1:0] w_pos_ext;
  logic [LIM_W-1:0] w_lim;

  assign w_pos_ext = {3'b000, i_pos};

  // Walk the boundaries k*ancho; the last boundary reached gives the index.
  always_comb begin
    w_lim    = '0;
    o_indice = '0;
    o_valido = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      w_lim = w_lim + {3'b000, i_ancho};
      if (k < int'(i_cuenta) && w_pos_ext >= w_lim) o_indice = IDX_W'(k);
      if (k == int'(i_cuenta)) o_valido = !i_pos[POS_W-1] && (w_pos_ext < w_lim);
    end
  end

endmodule

// File: rtl/patron_barras_rgb.sv
// RGB test-pattern generator: vertical, horizontal, scrolling vertical bars
// and a checkerboard. Pixel timing: COLUMNA/FILA presented in a cycle produce
// R/G/B on the following cycle, for every cycle (no handshake). MODO_SIG
// requests the next mode, which takes effect at the next FIN_TRAMA.
module patron_barras_rgb
  import barras_pkg::*;
#(
  parameter int H_OFFSET    = 216,
  parameter int V_OFFSET    = 27,
  parameter int ANCHO_BARRA = 100,
  parameter int ALTO_BARRA  = 60,
  parameter int NUM_BARRAS  = 8,
  parameter int VEL         = 4,   // assumed <= NUM_BARRAS*ANCHO_BARRA
  parameter int COLOR_W     = 8
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic [10:0]        COLUMNA,
  input  logic [10:0]        FILA,
  input  logic               FIN_TRAMA,
  input  logic               MODO_SIG,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic [1:0]         MODO,
  output logic               o_dbg_pendiente,
  output logic [POS_W-1:0]   o_dbg_despl
);

  localparam logic [POS_W-1:0] SPAN_H = POS_W'(NUM_BARRAS * ANCHO_BARRA);

  modo_t            r_modo, w_modo_sig;
  logic             r_pend, w_pend_sig, w_pend_req;
  logic [POS_W-1:0] r_despl, w_despl_sig, w_despl_suma;

  logic [POS_W-1:0] w_x, w_y, w_suma, w_x_despl, w_pos_col;
  logic             w_x_dentro;
  logic [IDX_W-1:0] w_col_idx, w_fil_idx, w_indice;
  logic             w_col_val, w_fil_val;
  logic [2:0]       w_rgb;

  assign MODO            = r_modo;
  assign o_dbg_pendiente = r_pend;
  assign o_dbg_despl     = r_despl;

  // State register: mode, pending request and scroll offset.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_modo  <= MODO_VERT;
      r_pend  <= 1'b0;
      r_despl <= '0;
    end else begin
      r_modo  <= w_modo_sig;
      r_pend  <= w_pend_sig;
      r_despl <= w_despl_sig;
    end
  end

  assign w_despl_suma = r_despl + POS_W'(VEL);

  // Next state: requests collapse into one pending flag consumed at frame end.
  always_comb begin
    w_pend_req  = r_pend | MODO_SIG;
    w_modo_sig  = r_modo;
    w_pend_sig  = w_pend_req;
    w_despl_sig = r_despl;
    if (FIN_TRAMA) begin
      w_pend_sig = 1'b0;
      if (w_pend_req) w_modo_sig = modo_siguiente(r_modo);
      if (w_pend_req && w_modo_sig == MODO_SCROLL) begin
        w_despl_sig = '0;
      end else if (r_modo == MODO_SCROLL) begin
        w_despl_sig = (w_despl_suma >= SPAN_H) ? w_despl_suma - SPAN_H : w_despl_suma;
      end
    end
  end

  // Positions relative to the pattern origin; negative values have the MSB set.
  assign w_x        = {5'b00000, COLUMNA} - POS_W'(H_OFFSET);
  assign w_y        = {5'b00000, FILA} - POS_W'(V_OFFSET);
  assign w_x_dentro = !w_x[POS_W-1] && (w_x < SPAN_H);
  assign w_suma     = w_x + r_despl;
  assign w_x_despl  = (w_suma >= SPAN_H) ? w_suma - SPAN_H : w_suma;
  assign w_pos_col  = (r_modo == MODO_SCROLL && w_x_dentro) ? w_x_despl : w_x;

  indice_barra u_idx_col (
    .i_pos    (w_pos_col),
    .i_ancho  (POS_W'(ANCHO_BARRA)),
    .i_cuenta (4'(NUM_BARRAS)),
    .o_indice (w_col_idx),
    .o_valido (w_col_val)
  );

  indice_barra u_idx_fil (
    .i_pos    (w_y),
    .i_ancho  (POS_W'(ALTO_BARRA)),
    .i_cuenta (4'(NUM_BARRAS)),
    .o_indice (w_fil_idx),
    .o_valido (w_fil_val)
  );

  // Output decode: palette index per mode, black outside the active spans.
  always_comb begin
    w_indice = IDX_NEGRO;
    case (r_modo)
      MODO_VERT, MODO_SCROLL: if (w_col_val) w_indice = w_col_idx;
      MODO_HORIZ:             if (w_fil_val) w_indice = w_fil_idx;
      MODO_DAMERO: begin
        if (w_col_val && w_fil_val && !(w_col_idx[0] ^ w_fil_idx[0]))
          w_indice = IDX_BLANCO;
      end
      default:                w_indice = IDX_NEGRO;
    endcase
    w_rgb = PALETA[w_indice];
  end

  // Registered colour output; each channel is fully on or off.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      R <= '0;
      G <= '0;
      B <= '0;
    end else begin
      R <= {COLOR_W{w_rgb[2]}};
      G <= {COLOR_W{w_rgb[1]}};
      B <= {COLOR_W{w_rgb[0]}};
    end
  end

endmodule
